axi_burst_slave_ram: RTL

AXI4 burst responder (slave) backed by on-chip dual-port RAM. It is the target for the aq_axi_master

---
 rtl/axi_slv_pkg.sv | 19 +
 rtl/axi_slv_ram.sv | 37 +++
 rtl/axi_burst_slave_ram.sv | 237 +++++++++++++++++++++++
 3 files changed

// File: rtl/axi_slv_pkg.sv
`timescale 1ns/1ps
// Shared response codes and FSM state types for the AXI burst slave RAM.
package axi_slv_pkg;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;
   localparam logic [1:0] RESP_DECERR = 2'b11;

   typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wr_state_t;
   typedef enum logic {R_IDLE, R_DATA} rd_state_t;

   // Out-of-range decode outranks a WLAST framing error.
   function automatic logic [1:0] wr_resp(input logic dec, input logic err);
      if (dec) return RESP_DECERR;
      if (err) return RESP_SLVERR;
      return RESP_OKAY;
   endfunction

endpackage

// File: rtl/axi_slv_ram.sv
`timescale 1ns/1ps
// Simple dual-port RAM: byte-enabled write on port A, registered read-first read on port B.
module axi_slv_ram #(
   parameter int DATA_W = 64,
   parameter int MEM_AW = 10
) (
   input  logic                  clk,
   input  logic                  a_we,
   input  logic [MEM_AW-1:0]     a_addr,
   input  logic [DATA_W/8-1:0]   a_be,
   input  logic [DATA_W-1:0]     a_din,
   input  logic                  b_re,
   input  logic [MEM_AW-1:0]     b_addr,
   output logic [DATA_W-1:0]     b_dout
);
   localparam int NB    = DATA_W / 8;
   localparam int DEPTH = 2 ** MEM_AW;

   // One 8-bit lane per byte enable; a same-address read sees the pre-write word.
   genvar gi;
   generate
      for (gi = 0; gi < NB; gi++) begin : g_lane
         logic [7:0] mem_reg [DEPTH];
         logic [7:0] dout_reg;

         always_ff @(posedge clk) begin
            if (a_we && a_be[gi])
               mem_reg[a_addr] <= a_din[gi*8 +: 8];
            if (b_re)
               dout_reg <= mem_reg[b_addr];
         end

         assign b_dout[gi*8 +: 8] = dout_reg;
      end
   endgenerate

endmodule

// File: rtl/axi_burst_slave_ram.sv
`timescale 1ns/1ps
// AXI4 INCR burst slave on dual-port RAM with independent write (AW/W/B) and read (AR/R) FSMs.
// Build option AXI_SLV_DECERR_EN: bursts starting above the RAM window answer DECERR instead of aliasing.
module axi_burst_slave_ram
   import axi_slv_pkg::*;
#(
   parameter int DATA_W = 64,
   parameter int MEM_AW = 10
) (
   input  logic                ACLK,
   input  logic                ARESETN,
   input  logic [31:0]         S_AXI_AWADDR,
   input  logic [7:0]          S_AXI_AWLEN,
   input  logic                S_AXI_AWVALID,
   output logic                S_AXI_AWREADY,
   input  logic [DATA_W-1:0]   S_AXI_WDATA,
   input  logic [DATA_W/8-1:0] S_AXI_WSTRB,
   input  logic                S_AXI_WLAST,
   input  logic                S_AXI_WVALID,
   output logic                S_AXI_WREADY,
   output logic [1:0]          S_AXI_BRESP,
   output logic                S_AXI_BVALID,
   input  logic                S_AXI_BREADY,
   input  logic [31:0]         S_AXI_ARADDR,
   input  logic [7:0]          S_AXI_ARLEN,
   input  logic                S_AXI_ARVALID,
   output logic                S_AXI_ARREADY,
   output logic [DATA_W-1:0]   S_AXI_RDATA,
   output logic [1:0]          S_AXI_RRESP,
   output logic                S_AXI_RLAST,
   output logic                S_AXI_RVALID,
   input  logic                S_AXI_RREADY
);

   // ---------------- write channel ----------------
   wr_state_t           wr_state_reg, wr_state_next;
   logic [MEM_AW-1:0]   waddr_reg;
   logic [7:0]          wlen_reg, wbeat_reg;
   logic                werr_reg, wdec_reg;
   logic                awready_reg, wready_reg, bvalid_reg;
   logic [1:0]          bresp_reg;
   logic                aw_hs, w_hs, w_last_beat, wlast_bad, aw_dec, ram_we;

   // ---------------- read channel -----------------
   rd_state_t           rd_state_reg, rd_state_next;
   logic                arready_reg;
   logic [MEM_AW-1:0]   raddr_reg;
   logic [7:0]          rlen_reg, rissue_reg;
   logic                rissue_done_reg, rdec_reg;
   logic                infl_reg, infl_last_reg;
   logic [1:0]          cnt_reg, occ;
   logic [DATA_W-1:0]   head_data_reg, skid_data_reg, push_data, ram_dout;
   logic [1:0]          head_resp_reg, skid_resp_reg, push_resp;
   logic                head_last_reg, skid_last_reg;
   logic                ar_hs, r_valid, r_pop, r_issue, ar_dec;

`ifdef AXI_SLV_DECERR_EN
   assign aw_dec = |S_AXI_AWADDR[31:MEM_AW+3];
   assign ar_dec = |S_AXI_ARADDR[31:MEM_AW+3];
`else
   assign aw_dec = 1'b0;
   assign ar_dec = 1'b0;
`endif

   logic unused_addr_bits;
   assign unused_addr_bits = ^{S_AXI_AWADDR[2:0], S_AXI_ARADDR[2:0],
                               S_AXI_AWADDR[31:MEM_AW+3], S_AXI_ARADDR[31:MEM_AW+3]};

   assign aw_hs       = awready_reg & S_AXI_AWVALID;
   assign w_hs        = wready_reg & S_AXI_WVALID;
   assign w_last_beat = (wbeat_reg == wlen_reg);
   assign wlast_bad   = (S_AXI_WLAST != w_last_beat);
   assign ram_we      = w_hs & ~wdec_reg;

   always_comb begin
      wr_state_next = wr_state_reg;
      case (wr_state_reg)
         W_IDLE:  if (aw_hs) wr_state_next = W_DATA;
         W_DATA:  if (w_hs && w_last_beat) wr_state_next = W_RESP;
         W_RESP:  if (bvalid_reg && S_AXI_BREADY) wr_state_next = W_IDLE;
         default: wr_state_next = W_IDLE;
      endcase
   end

   // Handshake outputs are registered from the next state so they stay low through reset.
   always_ff @(posedge ACLK or negedge ARESETN) begin
      if (!ARESETN) begin
         wr_state_reg <= W_IDLE;
         awready_reg  <= 1'b0;
         wready_reg   <= 1'b0;
         bvalid_reg   <= 1'b0;
         bresp_reg    <= RESP_OKAY;
         waddr_reg    <= '0;
         wlen_reg     <= 8'd0;
         wbeat_reg    <= 8'd0;
         werr_reg     <= 1'b0;
         wdec_reg     <= 1'b0;
      end else begin
         wr_state_reg <= wr_state_next;
         awready_reg  <= (wr_state_next == W_IDLE);
         wready_reg   <= (wr_state_next == W_DATA);
         bvalid_reg   <= (wr_state_next == W_RESP);
         if (aw_hs) begin
            waddr_reg <= S_AXI_AWADDR[MEM_AW+2:3];
            wlen_reg  <= S_AXI_AWLEN;
            wbeat_reg <= 8'd0;
            werr_reg  <= 1'b0;
            wdec_reg  <= aw_dec;
         end else if (w_hs) begin
            waddr_reg <= waddr_reg + MEM_AW'(1);
            wbeat_reg <= wbeat_reg + 8'd1;
            werr_reg  <= werr_reg | wlast_bad;
            if (w_last_beat)
               bresp_reg <= wr_resp(wdec_reg, werr_reg | wlast_bad);
         end else if (bvalid_reg && S_AXI_BREADY) begin
            bresp_reg <= RESP_OKAY;
         end
      end
   end

   axi_slv_ram #(.DATA_W(DATA_W), .MEM_AW(MEM_AW)) u_ram (
      .clk    (ACLK),
      .a_we   (ram_we),
      .a_addr (waddr_reg),
      .a_be   (S_AXI_WSTRB),
      .a_din  (S_AXI_WDATA),
      .b_re   (r_issue),
      .b_addr (raddr_reg),
      .b_dout (ram_dout)
   );

   assign ar_hs   = arready_reg & S_AXI_ARVALID;
   assign r_valid = (cnt_reg != 2'd0);
   assign r_pop   = r_valid & S_AXI_RREADY;
   // Queued beats plus the one in the RAM pipeline must never exceed the 2-entry skid.
   assign occ     = cnt_reg + {1'b0, infl_reg};
   assign r_issue = (rd_state_reg == R_DATA) && !rissue_done_reg && ((occ < 2'd2) || r_pop);

   assign push_data = rdec_reg ? '0 : ram_dout;
   assign push_resp = rdec_reg ? RESP_DECERR : RESP_OKAY;

   always_comb begin
      rd_state_next = rd_state_reg;
      case (rd_state_reg)
         R_IDLE:  if (ar_hs) rd_state_next = R_DATA;
         R_DATA:  if (r_pop && head_last_reg) rd_state_next = R_IDLE;
         default: rd_state_next = R_IDLE;
      endcase
   end

   always_ff @(posedge ACLK or negedge ARESETN) begin
      if (!ARESETN) begin
         rd_state_reg    <= R_IDLE;
         arready_reg     <= 1'b0;
         raddr_reg       <= '0;
         rlen_reg        <= 8'd0;
         rissue_reg      <= 8'd0;
         rissue_done_reg <= 1'b0;
         rdec_reg        <= 1'b0;
         infl_reg        <= 1'b0;
         infl_last_reg   <= 1'b0;
         cnt_reg         <= 2'd0;
         head_data_reg   <= '0;
         head_resp_reg   <= RESP_OKAY;
         head_last_reg   <= 1'b0;
         skid_data_reg   <= '0;
         skid_resp_reg   <= RESP_OKAY;
         skid_last_reg   <= 1'b0;
      end else begin
         rd_state_reg  <= rd_state_next;
         arready_reg   <= (rd_state_next == R_IDLE);
         infl_reg      <= r_issue;
         infl_last_reg <= r_issue && (rissue_reg == rlen_reg);
         if (ar_hs) begin
            raddr_reg       <= S_AXI_ARADDR[MEM_AW+2:3];
            rlen_reg        <= S_AXI_ARLEN;
            rissue_reg      <= 8'd0;
            rissue_done_reg <= 1'b0;
            rdec_reg        <= ar_dec;
         end else if (r_issue) begin
            raddr_reg  <= raddr_reg + MEM_AW'(1);
            rissue_reg <= rissue_reg + 8'd1;
            if (rissue_reg == rlen_reg)
               rissue_done_reg <= 1'b1;
         end
         // Head register drives the R channel; skid catches the beat already in flight.
         case ({infl_reg, r_pop})
            2'b10: begin
               if (cnt_reg == 2'd0) begin
                  head_data_reg <= push_data;
                  head_resp_reg <= push_resp;
                  head_last_reg <= infl_last_reg;
               end else begin
                  skid_data_reg <= push_data;
                  skid_resp_reg <= push_resp;
                  skid_last_reg <= infl_last_reg;
               end
               cnt_reg <= cnt_reg + 2'd1;
            end
            2'b01: begin
               if (cnt_reg == 2'd2) begin
                  head_data_reg <= skid_data_reg;
                  head_resp_reg <= skid_resp_reg;
                  head_last_reg <= skid_last_reg;
               end
               cnt_reg <= cnt_reg - 2'd1;
            end
            2'b11: begin
               if (cnt_reg == 2'd1) begin
                  head_data_reg <= push_data;
                  head_resp_reg <= push_resp;
                  head_last_reg <= infl_last_reg;
               end else begin
                  head_data_reg <= skid_data_reg;
                  head_resp_reg <= skid_resp_reg;
                  head_last_reg <= skid_last_reg;
                  skid_data_reg <= push_data;
                  skid_resp_reg <= push_resp;
                  skid_last_reg <= infl_last_reg;
               end
            end
            default: ;
         endcase
      end
   end

   assign S_AXI_AWREADY = awready_reg;
   assign S_AXI_WREADY  = wready_reg;
   assign S_AXI_BVALID  = bvalid_reg;
   assign S_AXI_BRESP   = bresp_reg;
   assign S_AXI_ARREADY = arready_reg;
   assign S_AXI_RVALID  = r_valid;
   assign S_AXI_RDATA   = head_data_reg;
   assign S_AXI_RRESP   = head_resp_reg;
   assign S_AXI_RLAST   = head_last_reg;

endmodule
